// File: rtl/sd_arbiter.sv
// sd_arbiter: round-robin arbiter sharing one SD block port between two requesters.
module sd_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd10000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  req_busy,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  input  logic [7:0]  buff_din0,
  input  logic [7:0]  buff_din1,
  output logic [1:0]  buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);
  typedef enum logic [2:0] {IDLE, ISSUE, XFER, RELEASE, DONE} state_t;
  state_t state, state_nxt;
  logic grant, last, op, ack_s, pick, timeout;
  logic [23:0] cnt;
  logic [1:0] ack_q, pend, gmask;
  assign ack_s   = ack_q[1];
  assign pend    = req_rd | req_wr;
  assign pick    = &pend ? ~last : pend[1];
  assign gmask   = grant ? 2'b10 : 2'b01;
  assign timeout = state == ISSUE && !ack_s && cnt == TIMEOUT - 24'd1;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = |pend ? ISSUE : IDLE;
      ISSUE:   state_nxt = ack_s ? XFER : timeout ? IDLE : ISSUE;
      XFER:    state_nxt = ack_s ? XFER : RELEASE;
      RELEASE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      grant  <= 1'b0;
      op     <= 1'b0;
      sd_lba <= '0;
      cnt    <= '0;
      ack_q  <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= {ack_q[0], sd_ack};
      if (state == IDLE && |pend) begin
        grant  <= pick;
        sd_lba <= pick ? req_lba1 : req_lba0;
        op     <= ~req_rd[pick];
        cnt    <= '0;
      end else if (state == ISSUE && cnt != 24'hFFFFFF) begin
        cnt <= cnt + 24'd1;
      end
      if (timeout || state == DONE) last <= grant;
    end
  end
  // op=1 means write; read wins when a requester asks for both
  assign req_busy    = state != IDLE ? gmask : 2'b00;
  assign req_done    = state == DONE ? gmask : 2'b00;
  assign req_err     = timeout ? gmask : 2'b00;
  assign sd_rd       = state == ISSUE && !op;
  assign sd_wr       = state == ISSUE && op;
  assign buff_wr     = sd_buff_wr && (state inside {ISSUE, XFER, RELEASE}) ? gmask : 2'b00;
  assign sd_buff_din = grant ? buff_din1 : buff_din0;
endmodule

// File: doc/sd_arbiter.md
SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd10000000, clk_sys cycles allowed in ISSUE before abort.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 req_rd  in  2  per-requester read request level; bit n = requester n.
REQ-005 req_wr  in  2  per-requester write request level.
REQ-006 req_lba0, req_lba1  in  32 each  sector address of requester 0 and 1.
REQ-007 req_busy  out  2  one-hot; high while requester n owns the SD port.
REQ-008 req_done  out  2  one-cycle pulse on transfer completion.
REQ-009 req_err  out  2  one-cycle pulse on timeout abort.
REQ-010 buff_din0, buff_din1  in  8 each  requester buffer read data for writes.
REQ-011 buff_wr  out  2  buffer write strobe routed to granted requester.
REQ-012 sd_lba  out  32  sector address to the IO controller.
REQ-013 sd_rd, sd_wr  out  1 each  block command to the IO controller.
REQ-014 sd_ack  in  1  IO-controller acknowledge, SPI_SCK domain (asynchronous).
REQ-015 sd_buff_wr  in  1  sector byte strobe from the IO controller.
REQ-016 sd_buff_din  out  8  write data muxed from the granted requester.

Function
REQ-017 sd_ack SHALL pass a 2-flop synchronizer; ack_s denotes the second flop output.
REQ-018 FSM states IDLE, ISSUE, XFER, RELEASE, DONE.
REQ-019 IDLE: pending(n) = req_rd[n] | req_wr[n]; with one pending, grant it; with both pending, grant the requester not granted last (round-robin, last = 1 after reset, so requester 0 wins first tie).
REQ-020 On grant: latch grant index, sd_lba <= req_lban, op <= rd if req_rd[n] else wr (read wins when both set; write stays pending for a later grant), go ISSUE next cycle.
REQ-021 ISSUE: sd_rd = (op==rd), sd_wr = (op==wr); on ack_s=1 deassert both and go XFER.
REQ-022 ISSUE timeout: counter reaches TIMEOUT-1 with ack_s=0 -> deassert sd_rd/sd_wr, pulse req_err[grant], go IDLE, update last.
REQ-023 XFER: on ack_s=0 go RELEASE.
REQ-024 RELEASE: exactly one cycle, then DONE (absorbs buffer-write strobes that trail ack).
REQ-025 DONE: pulse req_done[grant] for one cycle, update last = grant, return IDLE; next grant can be issued on the following cycle.
REQ-026 req_busy[grant] SHALL be high from the cycle after grant through DONE inclusive; never both bits high.
REQ-027 buff_wr[n] = sd_buff_wr & busy[n] & state in {ISSUE, XFER, RELEASE}, combinational; otherwise 0.
REQ-028 sd_buff_din = grant ? buff_din1 : buff_din0, combinational.
REQ-029 Request deassertion while busy SHALL be ignored; the operation runs to DONE or timeout.
REQ-030 A requester SHALL hold its request until req_done/req_err; a request still asserted in the cycle after DONE is treated as a new request.
REQ-031 sd_lba SHALL be stable from grant until the next grant.
REQ-032 The timeout counter SHALL clear on every entry to ISSUE; 24 bits, no wrap.

Reset
REQ-033 On reset: state IDLE, last=1, sd_rd=sd_wr=0, sd_lba=0, req_busy=req_done=req_err=0, synchronizer flops 0, counter 0.
REQ-034 Reset asserted mid-transfer SHALL abort immediately without req_done/req_err pulses.

Verification
REQ-035 req_rd=01, lba0=0x123 -> sd_lba=0x123, sd_rd=1 until ack_s rises; ack held 600 cycles, 512 sd_buff_wr -> 512 buff_wr[0] pulses, buff_wr[1]=0, one req_done=01.
REQ-036 req_rd=11 and req_wr=00 in the same cycle after reset -> requester 0 served, then 1; repeated ties alternate 0,1,0,1.
REQ-037 req_wr[1]=1, buff_din1=0xA5, buff_din0=0x5A -> sd_wr=1, sd_buff_din=0xA5 during the transfer, req_done=10.
REQ-038 TIMEOUT=16, req_rd=01, sd_ack held 0 -> sd_rd drops after 16 ISSUE cycles, req_err=01 for one cycle, no req_done.
REQ-039 reset pulsed while in XFER -> all outputs 0 next edge; after release, a pending req_rd=10 is granted normally.
REQ-040 req_rd[0]=1 and req_wr[0]=1 together -> read serviced first, then write as a separate transaction, two req_done pulses.
